// File: rtl/mrt_pkg.sv
// Shared constants, types and the reference value helper for the minroot
// output normalizer (redundant poly -> canonical integer mod the Pallas prime).
package mrt_pkg;

  localparam int NumCoeffs  = 17;
  localparam int WordBits   = 16;
  localparam int CoeffBits  = 17;
  localparam int TargetBits = 256;
  localparam int IterBits   = 48;

  localparam int NumBits    = WordBits * (NumCoeffs - 1) + CoeffBits;
  localparam int RedAccBits = NumBits + 1;
  localparam int ModMsb     = 254;
  localparam int RedSteps   = RedAccBits - (ModMsb + 1) + 1;
  localparam int CtrBits    = 5;
  localparam int CarryBits  = 2;
  localparam int SumBits    = CoeffBits + 1;

  localparam logic [TargetBits-1:0] Modulus =
    256'h40000000000000000000000000000000224698fc094cf91b992d30ed00000001;
  localparam logic [RedAccBits-1:0] ModulusAcc = RedAccBits'(Modulus);

  typedef logic [NumCoeffs-1:0][CoeffBits-1:0] poly_t;

  typedef enum logic [1:0] {
    IDLE,
    CARRY,
    REDUCE,
    OUT
  } norm_state_e;

  function automatic logic [RedAccBits-1:0] poly_value(input poly_t poly);
    logic [RedAccBits-1:0] sum;
    sum = '0;
    for (int i = 0; i < NumCoeffs; i++) begin
      sum = sum + (RedAccBits'(poly[i]) << (WordBits * i));
    end
    return sum;
  endfunction

endpackage

// File: rtl/mrt_poly_normalize_if.sv
// Job/result handshake bundle between the minroot engine, the normalizer
// and the result consumer. Signal suffixes are from the normalizer's view.
interface mrt_poly_normalize_if;
  import mrt_pkg::*;

  logic                  in_valid_i;
  logic                  in_ready_o;
  poly_t                 in_poly_i;
  logic [IterBits-1:0]   in_tag_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [TargetBits-1:0] out_data_o;
  logic [IterBits-1:0]   out_tag_o;
  logic                  busy_o;

  modport master (
    output in_valid_i,
    output in_poly_i,
    output in_tag_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_tag_o,
    input  busy_o
  );

  modport slave (
    input  in_valid_i,
    input  in_poly_i,
    input  in_tag_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_tag_o,
    output busy_o
  );

endinterface

// File: rtl/mrt_poly_normalize_shift_sub_step.sv
// One step of binary long reduction: subtract Modulus << shift from the
// accumulator when it fits, reporting whether the subtraction happened.
module mrt_shift_sub_step
  import mrt_pkg::*;
(
  input  logic [RedAccBits-1:0] acc,
  input  logic [CtrBits-1:0]    shift,
  output logic [RedAccBits-1:0] acc_sub,
  output logic                  took_sub
);

  logic [RedAccBits-1:0] shifted_mod;

  always_comb begin
    shifted_mod = ModulusAcc << shift;
    took_sub    = (acc >= shifted_mod);
    acc_sub     = took_sub ? (acc - shifted_mod) : acc;
  end

endmodule

// File: rtl/mrt_poly_normalize.sv
// Output normalizer: serial carry resolution of the redundant poly followed
// by a fixed-length shift/subtract reduction into [0, Modulus).
module mrt_poly_normalize
  import mrt_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  mrt_poly_normalize_if.slave bus
);

  norm_state_e           state, state_next;
  poly_t                 poly_q, poly_next;
  logic [IterBits-1:0]   tag_q, tag_next;
  logic [RedAccBits-1:0] acc, acc_next;
  logic [CtrBits-1:0]    ctr, ctr_next;
  logic [CarryBits-1:0]  carry, carry_next;
  logic [TargetBits-1:0] out_data, out_data_next;
  logic [IterBits-1:0]   out_tag, out_tag_next;

  logic [SumBits-1:0]    coeff_sum;
  logic [RedAccBits-1:0] sub_acc;
  logic                  took_sub;

  // ctr is the coefficient index in CARRY and the shift amount in REDUCE
  assign coeff_sum = SumBits'(poly_q[ctr]) + SumBits'(carry);

  mrt_shift_sub_step u_sub_step (
    .acc      (acc),
    .shift    (ctr),
    .acc_sub  (sub_acc),
    .took_sub (took_sub)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      poly_q   <= '0;
      tag_q    <= '0;
      acc      <= '0;
      ctr      <= '0;
      carry    <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      state    <= state_next;
      poly_q   <= poly_next;
      tag_q    <= tag_next;
      acc      <= acc_next;
      ctr      <= ctr_next;
      carry    <= carry_next;
      out_data <= out_data_next;
      out_tag  <= out_tag_next;
    end
  end

  always_comb begin
    state_next    = state;
    poly_next     = poly_q;
    tag_next      = tag_q;
    acc_next      = acc;
    ctr_next      = ctr;
    carry_next    = carry;
    out_data_next = out_data;
    out_tag_next  = out_tag;

    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b1;

    unique case (state)
      IDLE: begin
        bus.in_ready_o = 1'b1;
        bus.busy_o     = 1'b0;
        if (bus.in_valid_i) begin
          poly_next  = bus.in_poly_i;
          tag_next   = bus.in_tag_i;
          acc_next   = '0;
          ctr_next   = '0;
          carry_next = '0;
          state_next = CARRY;
        end
      end

      CARRY: begin
        if (ctr == CtrBits'(NumCoeffs - 1)) begin
          // The top coefficient keeps its full sum, so no carry is lost
          acc_next[RedAccBits-1:WordBits*(NumCoeffs-1)] = coeff_sum;
          carry_next = '0;
          ctr_next   = CtrBits'(RedSteps - 1);
          state_next = REDUCE;
        end else begin
          acc_next[int'(ctr)*WordBits +: WordBits] = coeff_sum[WordBits-1:0];
          carry_next = coeff_sum[SumBits-1:WordBits];
          ctr_next   = ctr + 1'b1;
        end
      end

      REDUCE: begin
        if (took_sub) begin
          acc_next = sub_acc;
        end
        if (ctr == '0) begin
          out_data_next = sub_acc[TargetBits-1:0];
          out_tag_next  = tag_q;
          state_next    = OUT;
        end else begin
          ctr_next = ctr - 1'b1;
        end
      end

      OUT: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.out_data_o = out_data;
  assign bus.out_tag_o  = out_tag;

  // The shift-subtract ladder only works if each step starts below 2*(M<<ctr)
  a_reduce_invariant : assert property (@(posedge clk_i) disable iff (rst_i)
    (state == REDUCE) |->
      ({1'b0, acc} < ({1'b0, ModulusAcc} << (ctr + 1'b1))));

  a_out_canonical : assert property (@(posedge clk_i) disable iff (rst_i)
    (state == OUT) |-> (out_data < Modulus));

  a_carry_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (state == CARRY) |-> (carry <= CarryBits'(2)));

endmodule

// File: tb/tb_mrt_poly_normalize.sv
// Directed bench for mrt_poly_normalize with a result scoreboard.
module tb_mrt_poly_normalize;
  import mrt_pkg::*;

  typedef struct packed {
    logic [TargetBits-1:0] data;
    logic [IterBits-1:0]   tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  exp_t sb[$];

  mrt_poly_normalize_if bus();

  mrt_poly_normalize dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [TargetBits-1:0] obs,
                       input logic [TargetBits-1:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic poly_t make_poly(input logic [TargetBits-1:0] v);
    poly_t p;
    p = '0;
    for (int i = 0; i < NumCoeffs - 1; i++) begin
      p[i] = {1'b0, v[i*WordBits +: WordBits]};
    end
    return p;
  endfunction

  function automatic poly_t add_poly(input poly_t a, input poly_t b);
    poly_t p;
    for (int i = 0; i < NumCoeffs; i++) begin
      p[i] = a[i] + b[i];
    end
    return p;
  endfunction

  task automatic applyStimulus(input poly_t poly, input logic [IterBits-1:0] tag,
                               input logic [TargetBits-1:0] expv);
    exp_t e;
    int   w;
    w = 0;
    while (bus.in_ready_o !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check("accept_ready", TargetBits'(bus.in_ready_o), TargetBits'(1));
    bus.in_valid_i = 1'b1;
    bus.in_poly_i  = poly;
    bus.in_tag_i   = tag;
    tick();
    bus.in_valid_i = 1'b0;
    e.data = expv;
    e.tag  = tag;
    sb.push_back(e);
    check("busy_after_accept", TargetBits'(bus.busy_o), TargetBits'(1));
  endtask

  task automatic wait_output(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      lat = k;
      if (bus.out_valid_o === 1'b1) break;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", TargetBits'(0), TargetBits'(1));
      return;
    end
    e = sb.pop_front();
    check("out_valid", TargetBits'(bus.out_valid_o), TargetBits'(1));
    check("out_data", bus.out_data_o, e.data);
    check("out_tag", TargetBits'(bus.out_tag_o), TargetBits'(e.tag));
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("in_ready_after_out", TargetBits'(bus.in_ready_o), TargetBits'(1));
    check("out_valid_cleared", TargetBits'(bus.out_valid_o), TargetBits'(0));
    check("data_hold_idle", bus.out_data_o, e.data);
  endtask

  task automatic run_job(input poly_t poly, input logic [IterBits-1:0] tag,
                         input logic [TargetBits-1:0] expv);
    int lat;
    applyStimulus(poly, tag, expv);
    wait_output(lat);
    check("latency", TargetBits'(lat), TargetBits'(37));
    checkOutput();
  endtask

  initial begin
    poly_t                 p;
    poly_t                 pmax;
    logic [TargetBits-1:0] exp_max;
    logic [TargetBits-1:0] held;
    int                    lat;

    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.in_poly_i   = '0;
    bus.in_tag_i    = '0;
    bus.out_ready_i = 1'b0;
    n_compared      = 0;
    n_mismatched    = 0;

    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    check("rst_out_valid", TargetBits'(bus.out_valid_o), TargetBits'(0));
    check("rst_in_ready", TargetBits'(bus.in_ready_o), TargetBits'(1));
    check("rst_busy", TargetBits'(bus.busy_o), TargetBits'(0));
    check("rst_out_data", bus.out_data_o, TargetBits'(0));
    check("rst_out_tag", TargetBits'(bus.out_tag_o), TargetBits'(0));

    $display("[TB] zero poly");
    run_job('0, 48'h1, TargetBits'(0));

    $display("[TB] redundant carry path");
    p    = '0;
    p[0] = 17'h1_0000;
    p[1] = 17'h1_FFFF;
    run_job(p, 48'h22, 256'h2_0000_0000);

    $display("[TB] exact modulus, modulus-1, 2M+5");
    run_job(make_poly(Modulus), 48'h333, TargetBits'(0));
    run_job(make_poly(Modulus - 1'b1), 48'h4444, Modulus - 1'b1);
    run_job(add_poly(make_poly(Modulus), make_poly(Modulus + 256'd5)),
            48'h5555_5, TargetBits'(5));

    $display("[TB] all coefficients at maximum");
    pmax    = '1;
    exp_max = TargetBits'(poly_value(pmax) % ModulusAcc);
    run_job(pmax, 48'hFFFF_FFFF_FFFF, exp_max);

    $display("[TB] output stall with ignored input pulses");
    applyStimulus(make_poly(256'h1234_5678_9ABC_DEF0), 48'hABCD,
                  256'h1234_5678_9ABC_DEF0);
    wait_output(lat);
    check("stall_latency", TargetBits'(lat), TargetBits'(37));
    held = 256'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid_i = (i % 3 == 0);
      bus.in_poly_i  = make_poly(256'hDEAD_0000 + TargetBits'(i));
      bus.in_tag_i   = 48'hBAD0 + 48'(i);
      tick();
      check("stall_valid", TargetBits'(bus.out_valid_o), TargetBits'(1));
      check("stall_data", bus.out_data_o, held);
    end
    bus.in_valid_i = 1'b0;
    check("stall_tag", TargetBits'(bus.out_tag_o), TargetBits'(48'hABCD));
    check("stall_in_ready", TargetBits'(bus.in_ready_o), TargetBits'(0));
    checkOutput();

    $display("[TB] back-to-back job after release");
    run_job(make_poly(Modulus + 256'd42), 48'h6, TargetBits'(42));

    $display("[TB] reset in the middle of REDUCE");
    applyStimulus(make_poly(256'h99), 48'h77, TargetBits'(256'h99));
    repeat (24) tick();
    check("busy_before_abort", TargetBits'(bus.busy_o), TargetBits'(1));
    rst            = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_poly_i  = make_poly(256'h55);
    bus.in_tag_i   = 48'h55;
    tick();
    rst            = 1'b0;
    bus.in_valid_i = 1'b0;
    sb.delete();
    check("abort_out_valid", TargetBits'(bus.out_valid_o), TargetBits'(0));
    check("abort_busy", TargetBits'(bus.busy_o), TargetBits'(0));
    check("abort_in_ready", TargetBits'(bus.in_ready_o), TargetBits'(1));
    run_job(make_poly(256'd7), 48'h8, TargetBits'(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
